// File: rtl/fetch_sequencer_if.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | fetch_sequencer_if : shared memory read port and run/ok decode handshake      |
// | Rev 1.0                                                                     |
// +-----------------------------------------------------------------------------+
interface fetch_sequencer_if #(
    parameter int ADDR_W = 19
);
    logic [ADDR_W-1:0] mem_raddr;
    logic [7:0]        mem_rdata;
    logic [ADDR_W-1:0] dec_raddr;
    logic [7:0]        dec_rdata;
    logic [31:0]       instr;
    logic              run;
    logic              ok;
    logic [31:0]       pc_wdata;
    logic              pc_wren;
    logic              intr;

    modport master (
        output mem_raddr, input  mem_rdata,
        input  dec_raddr, output dec_rdata,
        output instr,     output run,      input ok,
        input  pc_wdata,  input  pc_wren,  input intr
    );

    modport slave (
        input  mem_raddr, output mem_rdata,
        output dec_raddr, input  dec_rdata,
        input  instr,     input  run,      output ok,
        output pc_wdata,  output pc_wren,  output intr
    );
endinterface
`default_nettype wire

// File: rtl/fetch_sequencer.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | fetch_sequencer : PC owner, byte-wise instruction fetch, run/ok sequencing  |
// | Rev 1.0                                                                     |
// +-----------------------------------------------------------------------------+
module fetch_sequencer #(
    parameter int          ADDR_W   = 19,
    parameter logic [31:0] PC_RESET = 32'h0,
    parameter logic [31:0] TRAP_VEC = 32'h80,
    parameter int          TIMEOUT  = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              enable,
    fetch_sequencer_if.master bus,
    output logic [31:0]       pc,
    output logic              busy,
    output logic              err,
    output logic [31:0]       retired
);
    localparam int                c_wdog_w    = $clog2(TIMEOUT);
    localparam logic [c_wdog_w-1:0] c_wdog_last = c_wdog_w'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_EXEC  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t              r_state;
    state_t              w_state_next;
    logic [2:0]          r_k;
    logic [ADDR_W-1:0]   r_faddr;
    logic [31:0]         r_instr;
    logic [31:0]         r_pc;
    logic [31:0]         r_target;
    logic [31:0]         r_retired;
    logic                r_run;
    logic                r_err;
    logic                r_redirect;
    logic                r_trap;
    logic [c_wdog_w-1:0] r_wdog;
    logic                w_timeout;
    logic                w_trap;
    logic                w_redirect;
    logic [31:0]         w_target;

    assign w_timeout  = (r_wdog == c_wdog_last);
    // A redirect or interrupt arriving in the same cycle as ok still takes effect.
    assign w_trap     = r_trap | bus.intr;
    assign w_redirect = r_redirect | bus.pc_wren;
    assign w_target   = bus.pc_wren ? bus.pc_wdata : r_target;

    assign bus.mem_raddr = (r_state == S_EXEC) ? bus.dec_raddr : r_faddr;
    assign bus.dec_rdata = bus.mem_rdata;
    assign bus.instr     = r_instr;
    assign bus.run       = r_run;
    assign pc            = r_pc;
    assign busy          = (r_state != S_IDLE);
    assign err           = r_err;
    assign retired       = r_retired;

    always_ff @(posedge clk) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (enable) w_state_next = S_FETCH;
            S_FETCH: if (r_k == 3'd4) w_state_next = S_EXEC;
            S_EXEC:  if (bus.ok || w_timeout) w_state_next = S_DONE;
            S_DONE:  w_state_next = enable ? S_FETCH : S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_k        <= 3'd0;
            r_faddr    <= '0;
            r_instr    <= 32'h0;
            r_pc       <= PC_RESET;
            r_target   <= 32'h0;
            r_retired  <= 32'h0;
            r_run      <= 1'b0;
            r_err      <= 1'b0;
            r_redirect <= 1'b0;
            r_trap     <= 1'b0;
            r_wdog     <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (enable) begin
                        r_faddr <= r_pc[ADDR_W-1:0];
                        r_k     <= 3'd0;
                    end
                end
                S_FETCH: begin
                    // Read data lags the address by one cycle, so step k lands byte k-1.
                    case (r_k)
                        3'd1:    r_instr[7:0]   <= bus.mem_rdata;
                        3'd2:    r_instr[15:8]  <= bus.mem_rdata;
                        3'd3:    r_instr[23:16] <= bus.mem_rdata;
                        3'd4:    r_instr[31:24] <= bus.mem_rdata;
                        default: ;
                    endcase
                    r_faddr <= r_faddr + 1'b1;
                    r_k     <= r_k + 3'd1;
                    if (r_k == 3'd4) begin
                        r_run  <= 1'b1;
                        r_wdog <= '0;
                    end
                end
                S_EXEC: begin
                    if (bus.pc_wren) begin
                        r_redirect <= 1'b1;
                        r_target   <= bus.pc_wdata;
                    end
                    if (bus.intr) r_trap <= 1'b1;
                    r_wdog <= r_wdog + 1'b1;
                    if (bus.ok) begin
                        r_run     <= 1'b0;
                        r_retired <= r_retired + 32'd1;
                        if (w_trap)          r_pc <= TRAP_VEC;
                        else if (w_redirect) r_pc <= w_target;
                        else                 r_pc <= r_pc + 32'd4;
                    end else if (w_timeout) begin
                        r_run <= 1'b0;
                        r_err <= 1'b1;
                        r_pc  <= TRAP_VEC;
                    end
                end
                S_DONE: begin
                    r_redirect <= 1'b0;
                    r_trap     <= 1'b0;
                    if (enable) begin
                        r_faddr <= r_pc[ADDR_W-1:0];
                        r_k     <= 3'd0;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_fetch_sequencer.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | tb_fetch_sequencer : directed self-checking bench for fetch_sequencer       |
// | Rev 1.0                                                                     |
// +-----------------------------------------------------------------------------+
module tb_fetch_sequencer;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_na, ena, rst_nb, enb;
    logic [31:0] pc_a, retired_a, pc_b, retired_b;
    logic        busy_a, err_a, busy_b, err_b;
    int          checks   = 0;
    int          failures = 0;

    fetch_sequencer_if #(.ADDR_W(19)) bus_a();
    fetch_sequencer_if #(.ADDR_W(19)) bus_b();

    logic [7:0] mem [0:(1<<19)-1];

    always @(posedge clk) begin
        bus_a.mem_rdata <= mem[bus_a.mem_raddr];
        bus_b.mem_rdata <= mem[bus_b.mem_raddr];
    end

    fetch_sequencer u_dut_a (
        .clk(clk), .rst_n(rst_na), .enable(ena), .bus(bus_a.master),
        .pc(pc_a), .busy(busy_a), .err(err_a), .retired(retired_a)
    );

    fetch_sequencer #(.PC_RESET(32'hFFFF_FFFC)) u_dut_b (
        .clk(clk), .rst_n(rst_nb), .enable(enb), .bus(bus_b.master),
        .pc(pc_b), .busy(busy_b), .err(err_b), .retired(retired_b)
    );

    task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Starts just before FETCH k=0; ends at the negedge of the first EXEC cycle.
    task automatic a_fetch_exec(input string tag, input logic [31:0] base, input logic [31:0] exp_instr);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check_value({tag, "_addr"}, 32'(bus_a.mem_raddr), 32'(19'(base + 32'(i))));
        end
        @(negedge clk);
        check_value({tag, "_run_k4"}, 32'(bus_a.run), 32'd0);
        @(negedge clk);
        check_value({tag, "_run"}, 32'(bus_a.run), 32'd1);
        check_value({tag, "_instr"}, bus_a.instr, exp_instr);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "bench time limit");
    end

    initial begin
        int n;
        rst_na = 1'b0; ena = 1'b0; rst_nb = 1'b0; enb = 1'b0;
        bus_a.ok = 1'b0; bus_a.pc_wren = 1'b0; bus_a.intr = 1'b0;
        bus_a.pc_wdata = 32'h0; bus_a.dec_raddr = 19'h1234;
        bus_b.ok = 1'b0; bus_b.pc_wren = 1'b0; bus_b.intr = 1'b0;
        bus_b.pc_wdata = 32'h0; bus_b.dec_raddr = 19'h0;
        for (int i = 0; i < (1 << 19); i++) mem[i] = 8'(i * 7 + 3);
        mem[0] = 8'h09; mem[1] = 8'h20; mem[2] = 8'h00; mem[3] = 8'h01;
        mem[4] = 8'h13; mem[5] = 8'h57; mem[6] = 8'h9B; mem[7] = 8'hDF;
        mem[32'h40] = 8'hAA; mem[32'h41] = 8'hBB; mem[32'h42] = 8'hCC; mem[32'h43] = 8'hDD;
        mem[32'h80] = 8'h11; mem[32'h81] = 8'h22; mem[32'h82] = 8'h33; mem[32'h83] = 8'h44;
        mem[32'h7FFFC] = 8'h78; mem[32'h7FFFD] = 8'h56; mem[32'h7FFFE] = 8'h34; mem[32'h7FFFF] = 8'h12;

        repeat (3) @(negedge clk);
        check_value("rst_busy",    32'(busy_a), 32'd0);
        check_value("rst_pc",      pc_a, 32'h0);
        check_value("rst_run",     32'(bus_a.run), 32'd0);
        check_value("rst_instr",   bus_a.instr, 32'h0);
        check_value("rst_err",     32'(err_a), 32'd0);
        check_value("rst_retired", retired_a, 32'd0);
        check_value("rst_raddr",   32'(bus_a.mem_raddr), 32'd0);
        check_value("rst_pc_b",    pc_b, 32'hFFFF_FFFC);

        // Basic fetch from reset, then plain ok.
        rst_na = 1'b1; ena = 1'b1;
        a_fetch_exec("t1", 32'h0, 32'h0100_2009);
        check_value("t2_dec_mux", 32'(bus_a.mem_raddr), 32'h1234);
        repeat (6) @(negedge clk);
        bus_a.ok = 1'b1;
        @(negedge clk);
        check_value("t2_run",     32'(bus_a.run), 32'd0);
        check_value("t2_pc",      pc_a, 32'h4);
        check_value("t2_retired", retired_a, 32'd1);
        check_value("t2_busy",    32'(busy_a), 32'd1);
        bus_a.ok = 1'b0;

        // Redirect pulse ahead of ok.
        a_fetch_exec("t3a", 32'h4, 32'hDF9B_5713);
        @(negedge clk);
        bus_a.pc_wren = 1'b1; bus_a.pc_wdata = 32'h40;
        @(negedge clk);
        bus_a.pc_wren = 1'b0; bus_a.pc_wdata = 32'hDEAD_0000;
        @(negedge clk);
        bus_a.ok = 1'b1;
        @(negedge clk);
        check_value("t3_pc",      pc_a, 32'h40);
        check_value("t3_retired", retired_a, 32'd2);
        bus_a.ok = 1'b0;

        // Interrupt beats a same-cycle redirect.
        a_fetch_exec("t3b", 32'h40, 32'hDDCC_BBAA);
        @(negedge clk);
        bus_a.intr = 1'b1; bus_a.pc_wren = 1'b1; bus_a.pc_wdata = 32'h40;
        @(negedge clk);
        bus_a.intr = 1'b0; bus_a.pc_wren = 1'b0; bus_a.ok = 1'b1;
        @(negedge clk);
        check_value("t4_pc",      pc_a, 32'h80);
        check_value("t4_retired", retired_a, 32'd3);
        bus_a.ok = 1'b0;

        // Watchdog: ok never arrives.
        a_fetch_exec("t5a", 32'h80, 32'h4433_2211);
        n = 1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (!bus_a.run) break;
            n++;
        end
        check_value("t5_exec_cycles", 32'(n), 32'd64);
        check_value("t5_err",     32'(err_a), 32'd1);
        check_value("t5_pc",      pc_a, 32'h80);
        check_value("t5_retired", retired_a, 32'd3);

        // Retry at trap vector; enable dropped mid-EXEC stops at DONE.
        a_fetch_exec("t5b", 32'h80, 32'h4433_2211);
        ena = 1'b0;
        repeat (3) @(negedge clk);
        check_value("t5_run_held", 32'(bus_a.run), 32'd1);
        bus_a.ok = 1'b1;
        @(negedge clk);
        check_value("t5_pc_next",  pc_a, 32'h84);
        check_value("t5_retired2", retired_a, 32'd4);
        check_value("t5_err_stk",  32'(err_a), 32'd1);
        bus_a.ok = 1'b0;
        @(negedge clk);
        check_value("t5_idle", 32'(busy_a), 32'd0);

        // Reset in the middle of EXEC.
        ena = 1'b1;
        a_fetch_exec("t7", 32'h84, 32'hB4AD_A69F);
        @(negedge clk);
        rst_na = 1'b0;
        @(negedge clk);
        check_value("t7_run",     32'(bus_a.run), 32'd0);
        check_value("t7_pc",      pc_a, 32'h0);
        check_value("t7_err",     32'(err_a), 32'd0);
        check_value("t7_retired", retired_a, 32'd0);
        check_value("t7_busy",    32'(busy_a), 32'd0);
        ena = 1'b0;

        // Address wrap at the top of memory and PC wrap to zero.
        rst_nb = 1'b1; enb = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check_value("t6_addr", 32'(bus_b.mem_raddr), 32'h7FFFC + 32'(i));
        end
        repeat (2) @(negedge clk);
        check_value("t6_run",   32'(bus_b.run), 32'd1);
        check_value("t6_instr", bus_b.instr, 32'h1234_5678);
        bus_b.ok = 1'b1;
        @(negedge clk);
        check_value("t6_pc",      pc_b, 32'h0);
        check_value("t6_retired", retired_b, 32'd1);
        bus_b.ok = 1'b0;
        @(negedge clk);
        check_value("t6_next_addr", 32'(bus_b.mem_raddr), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
`default_nettype wire
